lut_ram_wide: RTL and testbench

// Parametrised successor to the 16-bit bus-chained LUT RAM core. Sits in the daisy-chained
// 16-bit register bus: every bus beat is registered through, and beats addressed to this core

---
 rtl/lut_ram_wide.sv | 105 ++++++++++
 tb/tb_lut_ram_wide.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_ram_wide.sv
// Bus-chained LUT RAM with a parametrised word width. Wide words are split into 16-bit bus chunks.
// A second, word-wide user port gives the fabric direct access to the same memory.
module lut_ram_wide #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned READ_ONLY = 0,
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      addr_i,
    input  logic [15:0]      wdata_i,
    input  logic [15:0]      rdata_i,
    input  logic             rw_i,
    input  logic             valid_i,
    output logic [15:0]      addr_o,
    output logic [15:0]      wdata_o,
    output logic [15:0]      rdata_o,
    output logic             rw_o,
    output logic             valid_o,
    input  logic [AW-1:0]    user_addr,
    input  logic [WIDTH-1:0] user_din,
    input  logic             user_we,
    output logic [WIDTH-1:0] user_dout
);

    localparam int unsigned NCH = (WIDTH + 15) / 16;
    localparam int unsigned CW  = NCH * 16;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    stage_q, stage_d;
    logic [CW-1:0]    snap_q, snap_d;
    logic [CW-1:0]    wide;
    logic [31:0]      off, chunk;
    logic [AW-1:0]    word;
    logic             hit, bus_commit, user_ok, user_wr;
    logic [15:0]      rdata_d;
    logic [WIDTH-1:0] user_dout_d;

    // Addresses below BASE_ADDR wrap to a huge offset, so the range test still rejects them.
    assign off     = 32'(addr_i) - 32'(BASE_ADDR);
    assign hit     = valid_i && (32'(addr_i) >= 32'(BASE_ADDR)) && (off < 32'(DEPTH * NCH));
    assign word    = AW'(off / 32'(NCH));
    assign chunk   = off % 32'(NCH);
    assign user_ok = 32'(user_addr) < 32'(DEPTH);
    assign user_wr = user_we && user_ok;

    always_comb begin
        stage_d    = stage_q;
        snap_d     = snap_q;
        rdata_d    = rdata_i;
        bus_commit = 1'b0;
        wide       = stage_q;
        for (int k = 0; k < int'(NCH); k++) begin
            if (chunk == 32'(k)) wide[k*16 +: 16] = wdata_i;
        end
        if (hit && rw_i && READ_ONLY == 0) begin
            if (chunk == 32'(NCH - 1)) begin
                bus_commit = 1'b1;
            end else begin
                stage_d = wide;
            end
        end else if (hit && !rw_i) begin
            if (chunk == 32'd0) begin
                snap_d  = CW'(mem_q[word]);
                rdata_d = snap_d[15:0];
            end else begin
                for (int k = 1; k < int'(NCH); k++) begin
                    if (chunk == 32'(k)) rdata_d = snap_q[k*16 +: 16];
                end
            end
        end
        user_dout_d = user_ok ? mem_q[user_addr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_o    <= '0;
            wdata_o   <= '0;
            rdata_o   <= '0;
            rw_o      <= 1'b0;
            valid_o   <= 1'b0;
            user_dout <= '0;
            stage_q   <= '0;
            snap_q    <= '0;
        end else begin
            addr_o    <= addr_i;
            wdata_o   <= wdata_i;
            rdata_o   <= rdata_d;
            rw_o      <= rw_i;
            valid_o   <= valid_i;
            user_dout <= user_dout_d;
            stage_q   <= stage_d;
            snap_q    <= snap_d;
        end
    end

    // Memory is not reset; the user write is issued last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (bus_commit) mem_q[word] <= WIDTH'(wide);
        if (user_wr) mem_q[user_addr] <= user_din;
    end

endmodule

// File: tb/tb_lut_ram_wide.sv
// Drives three differently configured lut_ram_wide instances from one shared bus and user port
// and compares every output against a word-level behavioural model each cycle.
module tb_lut_ram_wide;

    localparam int unsigned CWID [3] = '{33, 16, 20};
    localparam int unsigned CDEP [3] = '{5, 8, 8};
    localparam int unsigned CBAS [3] = '{16, 0, 32};
    localparam int unsigned CRO  [3] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;
    logic [2:0]  user_addr;
    logic [63:0] user_din;
    logic        user_we;

    logic [15:0] ob_addr [3];
    logic [15:0] ob_wdata [3];
    logic [15:0] ob_rdata [3];
    logic        ob_rw [3];
    logic        ob_valid [3];
    logic [32:0] ud0;
    logic [15:0] ud1;
    logic [19:0] ud2;
    logic [63:0] ob_ud [3];

    assign ob_ud[0] = 64'(ud0);
    assign ob_ud[1] = 64'(ud1);
    assign ob_ud[2] = 64'(ud2);

    always #5 clk = ~clk;

    lut_ram_wide #(.BASE_ADDR(16), .DEPTH(5), .WIDTH(33), .READ_ONLY(0)) u_dut0 (
        .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i), .addr_o(ob_addr[0]), .wdata_o(ob_wdata[0]),
        .rdata_o(ob_rdata[0]), .rw_o(ob_rw[0]), .valid_o(ob_valid[0]),
        .user_addr(user_addr), .user_din(user_din[32:0]), .user_we(user_we), .user_dout(ud0)
    );

    lut_ram_wide #(.BASE_ADDR(0), .DEPTH(8), .WIDTH(16), .READ_ONLY(0)) u_dut1 (
        .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i), .addr_o(ob_addr[1]), .wdata_o(ob_wdata[1]),
        .rdata_o(ob_rdata[1]), .rw_o(ob_rw[1]), .valid_o(ob_valid[1]),
        .user_addr(user_addr), .user_din(user_din[15:0]), .user_we(user_we), .user_dout(ud1)
    );

    lut_ram_wide #(.BASE_ADDR(32), .DEPTH(8), .WIDTH(20), .READ_ONLY(1)) u_dut2 (
        .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i), .addr_o(ob_addr[2]), .wdata_o(ob_wdata[2]),
        .rdata_o(ob_rdata[2]), .rw_o(ob_rw[2]), .valid_o(ob_valid[2]),
        .user_addr(user_addr), .user_din(user_din[19:0]), .user_we(user_we), .user_dout(ud2)
    );

    // Reference model state
    logic [63:0] m_mem [3][8];
    logic [15:0] m_stage [3][4];
    logic [63:0] m_snap [3];
    logic [15:0] e_addr, e_wdata;
    logic        e_rw, e_valid;
    logic [15:0] e_rdata [3];
    logic [63:0] e_ud [3];
    bit          chk_ud;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [63:0] wmask(int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] init_val(int k);
        return 64'h1_5A00_A500 | 64'(k) | (64'(k) << 16);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_addr  = '0;
        e_wdata = '0;
        e_rw    = 1'b0;
        e_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e_rdata[i] = '0;
            e_ud[i]    = '0;
            m_snap[i]  = '0;
            for (int k = 0; k < 4; k++) m_stage[i][k] = '0;
        end
    endtask

    task automatic model_clk();
        int unsigned nch, a, o, word, ch;
        logic        commit;
        logic [63:0] cval;
        for (int i = 0; i < 3; i++) begin
            nch        = (CWID[i] + 15) / 16;
            a          = 32'(addr_i);
            commit     = 1'b0;
            cval       = '0;
            word       = 0;
            e_rdata[i] = rdata_i;
            if (valid_i && a >= CBAS[i] && (a - CBAS[i]) < CDEP[i] * nch) begin
                o    = a - CBAS[i];
                word = o / nch;
                ch   = o % nch;
                if (rw_i) begin
                    if (CRO[i] == 0) begin
                        if (ch == nch - 1) begin
                            for (int k = 0; k < int'(nch) - 1; k++)
                                cval |= 64'(m_stage[i][k]) << (16 * k);
                            cval  |= 64'(wdata_i) << (16 * ch);
                            cval  &= wmask(CWID[i]);
                            commit = 1'b1;
                        end else begin
                            m_stage[i][ch] = wdata_i;
                        end
                    end
                end else if (ch == 0) begin
                    m_snap[i]  = m_mem[i][word];
                    e_rdata[i] = m_mem[i][word][15:0];
                end else begin
                    e_rdata[i] = 16'(m_snap[i] >> (16 * ch));
                end
            end
            e_ud[i] = (32'(user_addr) < CDEP[i]) ? m_mem[i][user_addr] : 64'd0;
            if (commit) m_mem[i][word] = cval;
            if (user_we && 32'(user_addr) < CDEP[i])
                m_mem[i][user_addr] = user_din & wmask(CWID[i]);
        end
        e_addr  = addr_i;
        e_wdata = wdata_i;
        e_rw    = rw_i;
        e_valid = valid_i;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("addr_o[%0d]", i), 64'(ob_addr[i]), 64'(e_addr));
            check($sformatf("wdata_o[%0d]", i), 64'(ob_wdata[i]), 64'(e_wdata));
            check($sformatf("rdata_o[%0d]", i), 64'(ob_rdata[i]), 64'(e_rdata[i]));
            check($sformatf("rw_o[%0d]", i), 64'(ob_rw[i]), 64'(e_rw));
            check($sformatf("valid_o[%0d]", i), 64'(ob_valid[i]), 64'(e_valid));
            if (chk_ud) check($sformatf("user_dout[%0d]", i), ob_ud[i], e_ud[i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clk();
        #1;
        check_all();
    endtask

    task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic rw,
                       input logic v);
        addr_i  = a;
        wdata_i = d;
        rw_i    = rw;
        valid_i = v;
    endtask

    task automatic user(input logic [2:0] ua, input logic [63:0] din, input logic we);
        user_addr = ua;
        user_din  = din;
        user_we   = we;
    endtask

    initial begin
        rst     = 1'b1;
        chk_ud  = 1'b0;
        rdata_i = '0;
        bus(16'h0, 16'h0, 1'b0, 1'b0);
        user(3'd0, 64'd0, 1'b0);
        #12;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset rdata_o[%0d]", i), 64'(ob_rdata[i]), 64'd0);
            check($sformatf("reset valid_o[%0d]", i), 64'(ob_valid[i]), 64'd0);
            check($sformatf("reset user_dout[%0d]", i), ob_ud[i], 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Fill every memory through the user port so later reads are fully defined.
        for (int k = 0; k < 8; k++) begin
            user(3'(k), init_val(k), 1'b1);
            cycle();
        end
        user(3'd0, 64'd0, 1'b0);
        chk_ud = 1'b1;
        cycle();

        // 16-bit write then read
        bus(16'h0003, 16'hBEEF, 1'b1, 1'b1);
        cycle();
        bus(16'h0003, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t1 rdata", 64'(ob_rdata[1]), 64'hBEEF);
        check("t1 valid", 64'(ob_valid[1]), 64'd1);
        bus(16'h0003, 16'h0000, 1'b0, 1'b0);
        cycle();

        // Chunked 33-bit write commits only on the last chunk
        bus(16'h0010, 16'h1111, 1'b1, 1'b1);
        cycle();
        bus(16'h0011, 16'h2222, 1'b1, 1'b1);
        cycle();
        bus(16'h0012, 16'h0003, 1'b1, 1'b1);
        cycle();
        check("t2 before commit", ob_ud[0], init_val(0) & wmask(33));
        bus(16'h0012, 16'h0000, 1'b0, 1'b0);
        cycle();
        check("t2 after commit", ob_ud[0], 64'h1_2222_1111);

        // Snapshot coherence, including a chunk-0 read colliding with a user write
        user(3'd1, 64'h0_ABCD_1234, 1'b1);
        cycle();
        user(3'd1, 64'd0, 1'b0);
        bus(16'h0013, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t3 chunk0", 64'(ob_rdata[0]), 64'h1234);
        user(3'd1, 64'd0, 1'b1);
        bus(16'h0014, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t3 chunk1", 64'(ob_rdata[0]), 64'hABCD);
        user(3'd1, 64'h1_9999_8888, 1'b1);
        bus(16'h0015, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t3 chunk2", 64'(ob_rdata[0]), 64'h0000);
        bus(16'h0013, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t3 collide chunk0", 64'(ob_rdata[0]), 64'h8888);
        user(3'd1, 64'd0, 1'b0);
        bus(16'h0014, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t3 after collide", 64'(ob_rdata[0]), 64'h9999);

        // Miss is pure pass-through
        rdata_i = 16'h5A5A;
        bus(16'h0040, 16'h0000, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++)
            check($sformatf("t4 miss rdata[%0d]", i), 64'(ob_rdata[i]), 64'h5A5A);
        check("t4 miss addr", 64'(ob_addr[0]), 64'h0040);
        rdata_i = 16'h0000;

        // Same-cycle bus commit and user write to word 2: user wins
        bus(16'h0016, 16'hAAAA, 1'b1, 1'b1);
        cycle();
        bus(16'h0017, 16'hBBBB, 1'b1, 1'b1);
        cycle();
        bus(16'h0018, 16'h0001, 1'b1, 1'b1);
        user(3'd2, 64'd7, 1'b1);
        cycle();
        user(3'd2, 64'd0, 1'b0);
        bus(16'h0000, 16'h0000, 1'b0, 1'b0);
        cycle();
        check("t5 collision", ob_ud[0], 64'd7);

        // Read-only instance ignores bus writes
        bus(16'h0024, 16'h1234, 1'b1, 1'b1);
        cycle();
        bus(16'h0025, 16'h5678, 1'b1, 1'b1);
        cycle();
        bus(16'h0024, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t5 read-only bus", 64'(ob_rdata[2]), 64'd7);
        check("t5 read-only user", ob_ud[2], 64'd7);

        // Reset between chunks discards the staged data
        bus(16'h0019, 16'hDEAD, 1'b1, 1'b1);
        cycle();
        bus(16'h0000, 16'h0000, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6 async addr_o[%0d]", i), 64'(ob_addr[i]), 64'd0);
            check($sformatf("t6 async valid_o[%0d]", i), 64'(ob_valid[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus(16'h001A, 16'h4444, 1'b1, 1'b1);
        cycle();
        bus(16'h001B, 16'h0001, 1'b1, 1'b1);
        cycle();
        user(3'd3, 64'd0, 1'b0);
        bus(16'h0014, 16'h0000, 1'b0, 1'b1);
        cycle();
        check("t6 snapshot cleared", 64'(ob_rdata[0]), 64'd0);
        bus(16'h0000, 16'h0000, 1'b0, 1'b0);
        cycle();
        check("t6 commit", ob_ud[0], 64'h1_4444_0000);

        // Randomised traffic on both ports
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) addr_i = 16'($urandom);
            else addr_i = 16'($urandom_range(0, 49));
            wdata_i   = 16'($urandom);
            rdata_i   = 16'($urandom);
            rw_i      = 1'($urandom);
            valid_i   = ($urandom_range(0, 3) != 0);
            user_addr = 3'($urandom);
            user_din  = {32'($urandom), 32'($urandom)};
            user_we   = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
